// File: rtl/rgbled_ctrl.sv
// Frame sequencer for a ws281x_drv chain: double-buffered per-LED colour store
// streamed one frame at a time through the driver's valid/ack/last handshake.
module rgbled_ctrl #(
  parameter int unsigned NumLeds = 2,
  parameter int unsigned IdxW    = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [23:0]     wr_data_i,
  input  logic            update_i,
  input  logic            off_i,
  output logic            busy_o,
  output logic            go_o,
  input  logic            drv_idle_i,
  output logic [23:0]     data_o,
  output logic            data_valid_o,
  output logic            data_last_o,
  input  logic            data_ack_i
);

  typedef enum logic [1:0] {StIdle, StStart, StSend, StWaitIdle} state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              off_q;
  logic              busy_q;
  logic              start;
  logic [NumLeds-1:0] wr_sel;
  logic [23:0]       staging_q [NumLeds];
  logic [23:0]       active_q  [NumLeds];

  // Out-of-range indices decode to no entry, so such writes are dropped.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NumLeds; i++) begin
      wr_sel[i] = wr_en_i && (32'(wr_idx_i) == i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    start     = 1'b0;
    if (update_i && (state_q != StIdle)) pending_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (update_i || pending_q) start = 1'b1;
      end
      StStart: state_d = StSend;
      StSend: begin
        if (data_ack_i) begin
          if (idx_q == LastIdx) state_d = StWaitIdle;
          else                  idx_d   = idx_q + IdxW'(1);
        end
      end
      StWaitIdle: begin
        // An update arriving together with drv_idle_i is served now, not lost.
        if (drv_idle_i) begin
          if (pending_q || update_i) start   = 1'b1;
          else                       state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d   = StStart;
      idx_d     = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      off_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      busy_q    <= (state_d != StIdle) || pending_d;
      if (start) off_q <= off_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumLeds; i++) begin
        staging_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumLeds; i++) begin
        if (wr_sel[i]) staging_q[i] <= wr_data_i;
        // Same-cycle write is forwarded into the snapshot.
        if (start) active_q[i] <= wr_sel[i] ? wr_data_i : staging_q[i];
      end
    end
  end

  assign go_o         = (state_q == StStart) || (state_q == StSend);
  assign data_valid_o = (state_q == StSend);
  assign data_last_o  = data_valid_o && (idx_q == LastIdx);
  assign data_o       = (data_valid_o && !off_q) ? active_q[idx_q] : 24'h0;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_rgbled_ctrl.sv
// Randomized bench for rgbled_ctrl: a frame-level model predicts every word sent,
// plus directed checks on NumLeds=1 (async reset) and NumLeds=3 (ignored index).
module tb_rgbled_ctrl;

  logic        clk;
  logic        rst_n, u1_rst_n;
  logic        wr_en, wr_idx, update, off, drv_idle, data_ack;
  logic [23:0] wr_data;
  logic        busy, go, valid, last;
  logic [23:0] data;

  logic        u1_update, u1_drv_idle, u1_ack, u1_busy, u1_go, u1_valid, u1_last;
  logic [23:0] u1_data;

  logic        u3_wr_en, u3_update, u3_ack, u3_busy, u3_go, u3_valid, u3_last;
  logic [1:0]  u3_wr_idx;
  logic [23:0] u3_wr_data, u3_data;
  logic [23:0] u3_vals [4];

  int n_checks, n_fail;

  // Model state
  logic [23:0] m_stage [2];
  logic [23:0] exp_frame [2];
  logic [23:0] m1_stage;
  bit          m_pend;
  bit          rnd_on, dir_off;
  bit          nxt_we, nxt_idx;
  logic [23:0] nxt_data;

  rgbled_ctrl #(.NumLeds(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .update_i(update), .off_i(off), .busy_o(busy), .go_o(go), .drv_idle_i(drv_idle),
    .data_o(data), .data_valid_o(valid), .data_last_o(last), .data_ack_i(data_ack)
  );

  rgbled_ctrl #(.NumLeds(1)) dut1 (
    .clk_i(clk), .rst_ni(u1_rst_n), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .update_i(u1_update), .off_i(off), .busy_o(u1_busy), .go_o(u1_go),
    .drv_idle_i(u1_drv_idle), .data_o(u1_data), .data_valid_o(u1_valid),
    .data_last_o(u1_last), .data_ack_i(u1_ack)
  );

  rgbled_ctrl #(.NumLeds(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(u3_wr_en), .wr_idx_i(u3_wr_idx),
    .wr_data_i(u3_wr_data), .update_i(u3_update), .off_i(off), .busy_o(u3_busy),
    .go_o(u3_go), .drv_idle_i(drv_idle), .data_o(u3_data), .data_valid_o(u3_valid),
    .data_last_o(u3_last), .data_ack_i(u3_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rupd();
    return rnd_on && ($urandom_range(0, 5) == 0);
  endfunction

  // One clock: drive inputs just after a negedge, commit the model at the posedge,
  // return at the next negedge. snap = a frame starts at this edge.
  task automatic drive_cycle(input bit upd, input bit ack, input bit idle, input bit snap);
    wr_idx  = 1'($urandom_range(0, 1));
    wr_data = 24'($urandom);
    if (nxt_we) begin
      wr_en = 1'b1; wr_idx = nxt_idx; wr_data = nxt_data; nxt_we = 1'b0;
    end else begin
      wr_en = rnd_on && ($urandom_range(0, 2) == 0);
    end
    off      = rnd_on ? ($urandom_range(0, 3) == 0) : dir_off;
    update   = upd;
    data_ack = ack;
    drv_idle = idle;
    @(posedge clk);
    if (wr_en) m_stage[wr_idx] = wr_data;
    if (wr_en && wr_idx == 1'b0) m1_stage = wr_data;
    if (upd) m_pend = 1'b1;
    if (snap) begin
      m_pend = 1'b0;
      for (int i = 0; i < 2; i++) exp_frame[i] = off ? 24'h0 : m_stage[i];
    end
    @(negedge clk);
  endtask

  // From idle: request a frame, then serve it and any frames that became pending.
  task automatic run_frames(input bit inject);
    bit more, inj;
    int d;
    more = 1'b1;
    inj  = inject;
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    while (more) begin
      check_eq("start_go", go, 1'b1);
      check_eq("start_valid", valid, 1'b0);
      check_eq("start_busy", busy, 1'b1);
      drive_cycle(rupd(), 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 2; w++) begin
        d = rnd_on ? $urandom_range(0, 3) : 3;
        for (int k = 0; k <= d; k++) begin
          check_eq("send_valid", valid, 1'b1);
          check_eq("send_go", go, 1'b1);
          check_eq("send_data", data, exp_frame[w]);
          check_eq("send_last", last, (w == 1));
          if (inj && w == 0 && k == 0) begin
            nxt_we = 1'b1; nxt_idx = 1'b1; nxt_data = 24'hABCDEF;
          end
          drive_cycle(rupd() || (inj && w == 0 && k < 2), (k == d), 1'b0, 1'b0);
        end
      end
      check_eq("wait_valid", valid, 1'b0);
      check_eq("wait_go", go, 1'b0);
      check_eq("wait_last", last, 1'b0);
      check_eq("wait_data", data, 24'h0);
      check_eq("wait_busy", busy, 1'b1);
      d = rnd_on ? $urandom_range(0, 4) : 2;
      for (int k = 0; k < d; k++) begin
        drive_cycle(rupd(), 1'b0, 1'b0, 1'b0);
        check_eq("gap_busy", busy, 1'b1);
        check_eq("gap_valid", valid, 1'b0);
      end
      more = m_pend;
      drive_cycle(1'b0, 1'b0, 1'b1, more);
      inj = 1'b0;
    end
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_go", go, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; u1_rst_n = 1'b0;
    wr_en = 1'b0; wr_idx = 1'b0; wr_data = '0; update = 1'b0; off = 1'b0;
    drv_idle = 1'b1; data_ack = 1'b0;
    u1_update = 1'b0; u1_drv_idle = 1'b1; u1_ack = 1'b0;
    u3_wr_en = 1'b0; u3_wr_idx = '0; u3_wr_data = '0; u3_update = 1'b0; u3_ack = 1'b0;
    u3_vals = '{24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 24'hD1D2D3};
    m_stage = '{24'h0, 24'h0}; exp_frame = '{24'h0, 24'h0}; m1_stage = '0;
    m_pend = 1'b0; rnd_on = 1'b0; dir_off = 1'b0; nxt_we = 1'b0; nxt_idx = 1'b0;
    nxt_data = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_go", go, 1'b0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_last", last, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_data", data, 24'h0);
    rst_n = 1'b1; u1_rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 1'b0);

    // Directed: two-word frame, acks three cycles after valid
    nxt_we = 1'b1; nxt_idx = 1'b0; nxt_data = 24'h112233;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    nxt_we = 1'b1; nxt_idx = 1'b1; nxt_data = 24'h445566;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_frames(1'b0);
    // Rewrite idx1 and double update during word 0: one extra frame
    run_frames(1'b1);
    // off_i blanks the frame, next frame restores stored colours
    dir_off = 1'b1;
    run_frames(1'b0);
    dir_off = 1'b0;
    run_frames(1'b0);

    rnd_on = 1'b1;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      run_frames(1'b0);
    end
    rnd_on = 1'b0;
    wr_en = 1'b0; update = 1'b0; data_ack = 1'b0; off = 1'b0; drv_idle = 1'b1;

    // NumLeds=1: only idx0 writes land; single word is last
    u1_update = 1'b1;
    @(negedge clk);
    u1_update = 1'b0;
    check_eq("n1_start_go", u1_go, 1'b1);
    check_eq("n1_start_valid", u1_valid, 1'b0);
    @(negedge clk);
    check_eq("n1_valid", u1_valid, 1'b1);
    check_eq("n1_last", u1_last, 1'b1);
    check_eq("n1_data", u1_data, m1_stage);
    #2 u1_rst_n = 1'b0;
    #1;
    check_eq("n1_arst_go", u1_go, 1'b0);
    check_eq("n1_arst_valid", u1_valid, 1'b0);
    check_eq("n1_arst_last", u1_last, 1'b0);
    check_eq("n1_arst_data", u1_data, 24'h0);
    check_eq("n1_arst_busy", u1_busy, 1'b0);
    @(negedge clk);
    u1_rst_n = 1'b1;
    @(negedge clk);
    check_eq("n1_rel_busy", u1_busy, 1'b0);
    u1_update = 1'b1;
    @(negedge clk);
    u1_update = 1'b0;
    @(negedge clk);
    check_eq("n1_cleared_data", u1_data, 24'h0);
    check_eq("n1_cleared_last", u1_last, 1'b1);
    u1_ack = 1'b1;
    @(negedge clk);
    u1_ack = 1'b0;
    check_eq("n1_after_valid", u1_valid, 1'b0);
    check_eq("n1_after_busy", u1_busy, 1'b1);
    @(negedge clk);
    check_eq("n1_idle_busy", u1_busy, 1'b0);

    // NumLeds=3: write to idx3 must not disturb the frame
    for (int i = 0; i < 4; i++) begin
      u3_wr_en = 1'b1; u3_wr_idx = 2'(i); u3_wr_data = u3_vals[i];
      @(negedge clk);
    end
    u3_wr_en = 1'b0;
    u3_update = 1'b1;
    @(negedge clk);
    u3_update = 1'b0;
    check_eq("n3_start_go", u3_go, 1'b1);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      check_eq("n3_valid", u3_valid, 1'b1);
      check_eq("n3_data", u3_data, u3_vals[w]);
      check_eq("n3_last", u3_last, (w == 2));
      u3_ack = 1'b1;
      @(negedge clk);
      u3_ack = 1'b0;
    end
    check_eq("n3_end_valid", u3_valid, 1'b0);
    check_eq("n3_end_busy", u3_busy, 1'b1);
    @(negedge clk);
    check_eq("n3_idle_busy", u3_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgbled_ctrl.md
Name: rgbled_ctrl

Overview:
Frame sequencer for the ws281x_drv RGB LED driver. It replaces the fixed "all off" tie-off so software can set a per-LED colour for a chain of NumLeds WS281x devices. It holds a double-buffered colour store and, on request, streams one frame through the driver's valid/ack/last handshake. It sits between a register-interface front end and ws281x_drv, in the same clock domain.

Parameters:
NumLeds, 2, number of LEDs in the chain (>=1)
IdxW, (NumLeds>1 ? $clog2(NumLeds) : 1), LED index width (derived; not overridden)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
wr_en_i  input  1  single-cycle write strobe to the staging colour store
wr_idx_i  input  IdxW  LED index for the write
wr_data_i  input  24  colour {G,R,B}, 8 bits each, same order as the driver's data_i
update_i  input  1  single-cycle pulse: send one frame
off_i  input  1  level; when sampled at frame start, the frame sends all-zero colours
busy_o  output  1  frame in progress or pending
go_o  output  1  to driver go_i
drv_idle_i  input  1  from driver idle_o
data_o  output  24  to driver data_i
data_valid_o  output  1  to driver data_valid_i
data_last_o  output  1  to driver data_last_i
data_ack_i  input  1  from driver data_ack_o

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, both colour stores all zero, pending=0, off_q=0.
- Staging store: staging[wr_idx_i] <= wr_data_i when wr_en_i=1, in any state. Writes with wr_idx_i >= NumLeds are ignored.
- Active store:
  - Leaving IDLE/WAIT_IDLE for START copies the whole staging store into active.
  - In the same cycle, off_q <= off_i.
  - A write in that same cycle is included in the copy (write-through to the copy source).
- pending flag:
  - Set by update_i in any state other than IDLE.
  - Cleared when a frame starts.
  - Multiple updates while busy collapse into one pending frame.
- busy_o: 1 when state != IDLE or pending=1. Registered.
- FSM states:
  - IDLE: go_o=0, valid=0. On update_i or pending -> START (copy, clear pending, idx<=0).
  - START: go_o=1, valid=0, one cycle. -> SEND.
  - SEND: go_o=1, data_valid_o=1.
    - data_o = off_q ? 0 : active[idx].
    - data_last_o = (idx == NumLeds-1).
    - Outputs are held stable until data_ack_i.
    - On data_ack_i with last=0: idx <= idx+1, and the next word is presented the following cycle.
    - On data_ack_i with last=1: -> WAIT_IDLE. valid, last and go drop the next cycle, and data_o returns to 0.
  - WAIT_IDLE: go_o=0, valid=0.
    - When drv_idle_i=1: -> START if pending (copy, clear pending), else -> IDLE.
    - This guarantees the driver's latch/reset gap completes before the next frame.
- Latency: update_i in IDLE at cycle 0 -> START at cycle 1, data_valid_o=1 at cycle 2.
- data_ack_i outside SEND is ignored. idx never exceeds NumLeds-1 (no wrap).
- NumLeds=1: data_last_o=1 on the first word.
- Reset mid-frame: outputs go to 0 immediately (async); the driver is reset by the same rst_ni.

Test Plan:
- Reset -> go_o, data_valid_o, data_last_o, busy_o = 0; data_o = 24'h0.
- Write idx0=24'h112233, idx1=24'h445566, pulse update_i, bench acks each word 3 cycles after valid -> data_o 112233 (last=0), then 445566 (last=1); valid low the cycle after the second ack; FSM enters WAIT_IDLE; busy_o falls after drv_idle_i=1.
- During SEND of word 0, write idx1=24'hABCDEF and pulse update_i twice -> current frame still sends 445566; exactly one further frame follows after drv_idle_i, sending ABCDEF at idx1.
- off_i=1 at update with non-zero colours -> both words 24'h000000; the next frame with off_i=0 restores the stored colours.
- wr_idx_i=3 with NumLeds=2 (IdxW=1 truncation disabled via NumLeds=3 build, idx=3) -> store unchanged, frame data unaffected.
- NumLeds=1 build: update -> single word with data_last_o=1; assert rst_ni low mid-SEND -> all outputs 0 asynchronously, busy_o=0 after release.
